uart_rx_ctrl: RTL

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl_if.sv | 37 +++
 rtl/uart_rx_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl_if.sv
// Bundled control/status signals of the UART receive controller.
// The slave side is the controller; the master side is the register block plus the receiver datapath.
interface uart_rx_ctrl_if #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic                 enable;
  logic                 flush;
  logic                 rx_en;
  logic                 rx_rst;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_done;
  logic                 rx_error;
  logic                 rx_busy;
  logic                 rd_en;
  logic [DATA_BITS-1:0] rd_data;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [LW-1:0]        fifo_level;
  logic [LW-1:0]        thresh;
  logic                 clr_err;
  logic                 frame_err;
  logic                 overrun;
  logic                 irq;

  modport slave (
    input  enable, flush, rx_data, rx_done, rx_error, rx_busy, rd_en, thresh, clr_err,
    output rx_en, rx_rst, rd_data, fifo_empty, fifo_full, fifo_level, frame_err, overrun, irq
  );

  modport master (
    output enable, flush, rx_data, rx_done, rx_error, rx_busy, rd_en, thresh, clr_err,
    input  rx_en, rx_rst, rd_data, fifo_empty, fifo_full, fifo_level, frame_err, overrun, irq
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: receiver enable/recovery sequencing, first-word
// fall-through receive FIFO, sticky error flags and a registered interrupt.
module uart_rx_ctrl #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          PRESETn,
  uart_rx_ctrl_if.slave bus
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    DISABLED = 3'd0,
    ARM      = 3'd1,
    ACTIVE   = 3'd2,
    RECOVER  = 3'd3,
    DRAIN    = 3'd4
  } state_e;

  state_e state_q, state_d;
  logic   rx_en_q, rx_en_d;
  logic   rx_rst_q, rx_rst_d;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q, wr_ptr_nx, rd_ptr_nx;
  logic [LW-1:0]        level_q, level_nx;
  logic [DATA_BITS-1:0] rd_data_q, head_nx;
  logic                 frame_err_q, overrun_q, irq_q;
  logic                 accept, push, pop, full, wr_fire, overflow;

  // State and receiver control registers
  always_ff @(posedge clk or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= DISABLED;
      rx_en_q  <= 1'b0;
      rx_rst_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rx_en_q  <= rx_en_d;
      rx_rst_q <= rx_rst_d;
    end
  end

  // Next state; receiver controls follow the state being entered so they stay registered
  always_comb begin
    state_d  = state_q;
    rx_en_d  = 1'b0;
    rx_rst_d = 1'b0;
    case (state_q)
      DISABLED: if (bus.enable) state_d = ARM;
      ARM:      state_d = ACTIVE;
      ACTIVE: begin
        if (bus.rx_error)    state_d = RECOVER;
        else if (!bus.enable) state_d = DRAIN;
      end
      RECOVER:  state_d = bus.enable ? ACTIVE : DISABLED;
      DRAIN: begin
        if (bus.enable)        state_d = ACTIVE;
        else if (!bus.rx_busy) state_d = DISABLED;
      end
      default:  state_d = DISABLED;
    endcase
    rx_en_d  = (state_d == ACTIVE) || (state_d == DRAIN);
    rx_rst_d = (state_d == ARM) || (state_d == RECOVER);
  end

  // FIFO control; flush overrides both push and pop
  always_comb begin
    accept    = (state_q == ACTIVE) || (state_q == DRAIN);
    full      = (level_q == LW'(FIFO_DEPTH));
    push      = accept && bus.rx_done && !bus.rx_error && !bus.flush;
    pop       = bus.rd_en && (level_q != '0) && !bus.flush;
    wr_fire   = push && (!full || pop);
    overflow  = push && full && !pop;
    wr_ptr_nx = bus.flush ? '0 : wr_ptr_q + PW'(wr_fire);
    rd_ptr_nx = bus.flush ? '0 : rd_ptr_q + PW'(pop);
    level_nx  = bus.flush ? '0 : level_q + LW'(wr_fire) - LW'(pop);
    head_nx   = '0;
    if (level_nx != '0) begin
      // The new head may be the word being written this very cycle
      if (wr_fire && (wr_ptr_q == rd_ptr_nx)) head_nx = bus.rx_data;
      else                                    head_nx = mem[rd_ptr_nx];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr_q] <= bus.rx_data;
  end

  always_ff @(posedge clk or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rd_data_q   <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_nx;
      rd_ptr_q    <= rd_ptr_nx;
      level_q     <= level_nx;
      rd_data_q   <= head_nx;
      frame_err_q <= bus.rx_error ? 1'b1 : (bus.clr_err ? 1'b0 : frame_err_q);
      overrun_q   <= overflow     ? 1'b1 : (bus.clr_err ? 1'b0 : overrun_q);
      irq_q       <= ((bus.thresh != '0) && (level_q >= bus.thresh)) || frame_err_q || overrun_q;
    end
  end

  assign bus.rx_en      = rx_en_q;
  assign bus.rx_rst     = rx_rst_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.fifo_level = level_q;
  assign bus.fifo_empty = (level_q == '0);
  assign bus.fifo_full  = (level_q == LW'(FIFO_DEPTH));
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;
  assign bus.irq        = irq_q;
endmodule
